// File: rtl/ufm_dump_ctrl.sv
// Walks a window of UFM pages byte by byte and streams each byte out through a
// UART-style handshake. Optional burst header (0x55, sequence) under UFM_DUMP_HEADER_EN.
module ufm_dump_ctrl #(
  parameter int unsigned START_PAGE   = 2042,
  parameter int unsigned NUM_PAGES    = 4,
  parameter int unsigned BREAK_CYCLES = 12090000,
  parameter bit          CONTINUOUS   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [14:0] src_addr,
  output logic        src_rd,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [10:0] PAGE0    = 11'(START_PAGE);
  localparam logic [3:0]  LAST_OFF = 4'(NUM_PAGES - 1);
  localparam logic [31:0] BRK_M1   = (BREAK_CYCLES == 0) ? 32'd0 : 32'(BREAK_CYCLES - 1);

`ifdef UFM_DUMP_HEADER_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_PAUSE, S_HDR0, S_HDR1} state_t;
  logic [7:0] seq;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_PAUSE} state_t;
`endif

  state_t      state;
  logic [3:0]  byte_r;
  logic [3:0]  off_r;
  logic [31:0] pause_cnt;
  logic        last;

  function automatic logic [14:0] addr_of(input logic [3:0] off, input logic [3:0] byt);
    logic [10:0] pg;
    pg = PAGE0 + {7'd0, off};
    return {pg, byt};
  endfunction

  assign last = (byte_r == 4'd15) && (off_r == LAST_OFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      byte_r    <= '0;
      off_r     <= '0;
      pause_cnt <= '0;
      src_addr  <= '0;
      src_rd    <= 1'b0;
      tx_data   <= '0;
      tx_wr     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef UFM_DUMP_HEADER_EN
      seq       <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Drop whatever is in flight, including a half-finished tx handshake.
        state  <= S_IDLE;
        src_rd <= 1'b0;
        tx_wr  <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            byte_r <= '0;
            off_r  <= '0;
            busy   <= 1'b1;
`ifdef UFM_DUMP_HEADER_EN
            state   <= S_HDR0;
            tx_data <= 8'h55;
            tx_wr   <= 1'b1;
`else
            state    <= S_FETCH;
            src_addr <= addr_of(4'd0, 4'd0);
            src_rd   <= 1'b1;
`endif
          end
          S_FETCH: if (src_valid) begin
            tx_data <= src_data;
            src_rd  <= 1'b0;
            tx_wr   <= 1'b1;
            state   <= S_SEND;
          end
          S_SEND: if (tx_ready) begin
            tx_wr <= 1'b0;
            if (last) begin
              done      <= 1'b1;
              byte_r    <= '0;
              off_r     <= '0;
              pause_cnt <= BRK_M1;
`ifdef UFM_DUMP_HEADER_EN
              seq       <= seq + 8'd1;
`endif
              if (!CONTINUOUS) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else if (BREAK_CYCLES == 0) begin
`ifdef UFM_DUMP_HEADER_EN
                state   <= S_HDR0;
                tx_data <= 8'h55;
                tx_wr   <= 1'b1;
`else
                state    <= S_FETCH;
                src_addr <= addr_of(4'd0, 4'd0);
                src_rd   <= 1'b1;
`endif
              end else begin
                state <= S_PAUSE;
              end
            end else begin
              // Page offset advances together with the 15->0 byte wrap.
              byte_r   <= byte_r + 4'd1;
              if (byte_r == 4'd15) off_r <= off_r + 4'd1;
              src_addr <= addr_of((byte_r == 4'd15) ? off_r + 4'd1 : off_r, byte_r + 4'd1);
              src_rd   <= 1'b1;
              state    <= S_FETCH;
            end
          end
          S_PAUSE: begin
            if (pause_cnt == 32'd0) begin
`ifdef UFM_DUMP_HEADER_EN
              state   <= S_HDR0;
              tx_data <= 8'h55;
              tx_wr   <= 1'b1;
`else
              state    <= S_FETCH;
              src_addr <= addr_of(4'd0, 4'd0);
              src_rd   <= 1'b1;
`endif
            end else begin
              pause_cnt <= pause_cnt - 32'd1;
            end
          end
`ifdef UFM_DUMP_HEADER_EN
          S_HDR0: if (tx_ready) begin
            tx_data <= seq;
            state   <= S_HDR1;
          end
          S_HDR1: if (tx_ready) begin
            tx_wr    <= 1'b0;
            src_addr <= addr_of(4'd0, 4'd0);
            src_rd   <= 1'b1;
            state    <= S_FETCH;
          end
`endif
          default: begin
            state  <= S_IDLE;
            src_rd <= 1'b0;
            tx_wr  <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
